// File: rtl/wb_spram_ctrl_pkg.sv
// Shared types and widths for the Wishbone single-port RAM controller.
package wb_spram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_e;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

endpackage

// File: rtl/wb_spram_ctrl_clear.sv
// Post-reset zero-fill sequencer: walks every RAM word once, then raises clr_done.
// Only compiled when WB_SPRAM_CTRL_CLEAR_EN is defined.
`ifdef WB_SPRAM_CTRL_CLEAR_EN
module wb_spram_clear
  import wb_spram_pkg::*;
#(
  parameter int size       = 'h80,
  parameter int addr_width = $clog2(size) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_active,
  output logic [addr_width-1:0] clr_addr,
  output logic                  clr_done
);

  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(size / 4 - 1);

  logic [addr_width-1:0] addr_q, addr_d;
  logic                  done_q, done_d;

  always_comb begin
    addr_d = addr_q;
    done_d = done_q;
    if (clr_active) begin
      if (addr_q == LAST_ADDR) begin
        done_d = 1'b1;
      end else begin
        addr_d = addr_q + {{(addr_width-1){1'b0}}, 1'b1};
      end
    end else begin
      addr_d = addr_q;
      done_d = done_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end

  // Held off while rst is high so the first fill write lands on the first free cycle.
  assign clr_active = !done_q && !rst;
  assign clr_addr   = addr_q;
  assign clr_done   = done_q;

endmodule
`endif

// File: rtl/wb_spram_ctrl.sv
// Wishbone B4 pipelined slave driving a single-port 32-bit RAM with 1-cycle read latency.
// Optional zero-fill after reset when WB_SPRAM_CTRL_CLEAR_EN is defined.
module wb_spram_ctrl
  import wb_spram_pkg::*;
#(
  parameter int size       = 'h80,
  parameter int addr_width = $clog2(size) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [addr_width-1:0] wb_adr,
  input  logic [WB_SELW-1:0]    wb_sel,
  input  logic [WB_DW-1:0]      wb_dat_i,
  output logic [WB_DW-1:0]      wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_stall,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_ce,
  output logic [WB_SELW-1:0]    ram_we,
  output logic [WB_DW-1:0]      ram_d,
  input  logic [WB_DW-1:0]      ram_q,
  output logic                  init_done
);

  ctrl_state_e state_q;
  logic        ack_q;
  logic        stall_q;
  logic        init_done_q;
  logic        accept_s;
  logic        clr_last_s;

`ifdef WB_SPRAM_CTRL_CLEAR_EN
  localparam ctrl_state_e RESET_STATE = CLEAR;
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(size / 4 - 1);

  logic                  clr_active_s;
  logic [addr_width-1:0] clr_addr_s;
  logic                  clr_done_s;

  wb_spram_clear #(
    .size       (size),
    .addr_width (addr_width)
  ) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clr_active (clr_active_s),
    .clr_addr   (clr_addr_s),
    .clr_done   (clr_done_s)
  );

  assign clr_last_s = (clr_active_s && (clr_addr_s == LAST_ADDR)) || clr_done_s;
`else
  localparam ctrl_state_e RESET_STATE = RUN;
  assign clr_last_s = 1'b1;
`endif

  assign accept_s = wb_cyc && wb_stb && !stall_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      ack_q       <= 1'b0;
      stall_q     <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      ack_q <= accept_s;
      case (state_q)
        CLEAR: begin
          // Leave CLEAR on the edge that commits the last fill write.
          if (clr_last_s) begin
            state_q     <= RUN;
            stall_q     <= 1'b0;
            init_done_q <= 1'b1;
          end else begin
            stall_q     <= 1'b1;
            init_done_q <= 1'b0;
          end
        end
        RUN: begin
          stall_q     <= 1'b0;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= RESET_STATE;
          stall_q     <= 1'b1;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = 4'h0;
    ram_addr = wb_adr;
    ram_d    = wb_dat_i;
`ifdef WB_SPRAM_CTRL_CLEAR_EN
    if (clr_active_s) begin
      ram_ce   = 1'b1;
      ram_we   = 4'hF;
      ram_addr = clr_addr_s;
      ram_d    = 32'h0000_0000;
    end else
`endif
    if (accept_s) begin
      ram_ce = 1'b1;
      ram_we = wb_we ? wb_sel : 4'h0;
    end else begin
      ram_ce = 1'b0;
      ram_we = 4'h0;
    end
  end

  // Dropping wb_cyc in the ack cycle aborts the ack; the RAM access already happened.
  assign wb_ack    = ack_q && wb_cyc;
  assign wb_dat_o  = ram_q;
  assign wb_stall  = stall_q;
  assign init_done = init_done_q;

endmodule
